// File: rtl/epp_ram_writer_pkg.sv
// rtl/epp_ram_writer_pkg.sv - shared register indices, CTRL bits and FSM states for the EPP RAM writer
package epp_ram_writer_pkg;

    localparam logic [1:0] REG_ADDR_LO = 2'd0;
    localparam logic [1:0] REG_ADDR_HI = 2'd1;
    localparam logic [1:0] REG_DATA    = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int CTRL_CLR_BIT  = 0;
    localparam int CTRL_WRAP_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STROBE  = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } epp_state_t;

endpackage

// File: rtl/epp_ram_writer_sync.sv
// rtl/epp_ram_writer_sync.sv - SYNC_N-deep synchroniser for one asynchronous EPP pin, idles high
module epp_sync #(
    parameter int SYNC_N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_N-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_N-2:0], d};
        end
    end

    assign q = chain[SYNC_N-1];

endmodule

// File: rtl/epp_ram_writer.sv
// rtl/epp_ram_writer.sv - EPP register file driving RAM write port A with auto-increment
module epp_ram_writer
    import epp_ram_writer_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int SYNC_N = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              astb_n,
    input  logic              dstb_n,
    input  logic              pwr_n,
    input  logic [7:0]        db_in,
    output logic [7:0]        db_out,
    output logic              db_oe,
    output logic              pwait,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic [15:0]       wr_count
);

    localparam int SCW = $clog2(SYNC_N + 1);

    logic       astb_s, dstb_s, pwr_s;
    epp_state_t state, state_next;
    logic [1:0] epp_addr;
    logic       is_addr, is_write, wrap_flag;
    logic       need_release, settled;
    logic [SCW-1:0] settle_cnt;
    logic [15:0]    addr_ext;

    epp_sync #(.SYNC_N(SYNC_N)) u_sync_astb (.clk(clk), .rst(rst), .d(astb_n), .q(astb_s));
    epp_sync #(.SYNC_N(SYNC_N)) u_sync_dstb (.clk(clk), .rst(rst), .d(dstb_n), .q(dstb_s));
    epp_sync #(.SYNC_N(SYNC_N)) u_sync_pwr  (.clk(clk), .rst(rst), .d(pwr_n),  .q(pwr_s));

    // Synchronisers come out of reset reading "idle"; wait for them to refill
    // before trusting them, and swallow a strobe that was already low at reset.
    assign settled  = (settle_cnt == SCW'(SYNC_N));
    assign addr_ext = 16'(ram_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (settled && (!astb_s || !dstb_s)) begin
                    state_next = need_release ? ST_RELEASE : ST_STROBE;
                end
            end
            ST_STROBE:  state_next = ST_ACK;
            ST_ACK:     state_next = ST_RELEASE;
            ST_RELEASE: begin
                if (astb_s && dstb_s) begin
                    state_next = ST_IDLE;
                end
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwait        <= 1'b0;
            db_oe        <= 1'b0;
            db_out       <= 8'h00;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_din      <= 8'h00;
            wr_count     <= 16'h0000;
            epp_addr     <= 2'd0;
            is_addr      <= 1'b0;
            is_write     <= 1'b0;
            wrap_flag    <= 1'b0;
            need_release <= 1'b1;
            settle_cnt   <= '0;
        end else begin
            ram_we <= 1'b0;
            if (!settled) begin
                settle_cnt <= settle_cnt + SCW'(1);
            end
            if (settled && astb_s && dstb_s) begin
                need_release <= 1'b0;
            end
            if (state == ST_IDLE && state_next == ST_STROBE) begin
                is_addr  <= !astb_s;
                is_write <= !pwr_s;
            end

            // Increment runs the cycle after the strobe, so ram_addr is stable during ram_we.
            if (ram_we) begin
                ram_addr <= ram_addr + ADDR_W'(1);
                if (ram_addr == '1) begin
                    wrap_flag <= 1'b1;
                end
                if (wr_count != 16'hFFFF) begin
                    wr_count <= wr_count + 16'd1;
                end
            end

            if (state == ST_STROBE) begin
                pwait <= 1'b1;
                if (is_write) begin
                    if (is_addr) begin
                        epp_addr <= db_in[1:0];
                    end else begin
                        case (epp_addr)
                            REG_ADDR_LO: ram_addr[7:0] <= db_in;
                            REG_ADDR_HI: ram_addr <= ADDR_W'({db_in, ram_addr[7:0]});
                            REG_DATA: begin
                                ram_din <= db_in;
                                ram_we  <= 1'b1;
                            end
                            default: begin
                                if (db_in[CTRL_CLR_BIT]) begin
                                    ram_addr  <= '0;
                                    wr_count  <= 16'h0000;
                                    wrap_flag <= 1'b0;
                                end
                            end
                        endcase
                    end
                end else begin
                    db_oe <= 1'b1;
                    case (epp_addr)
                        REG_ADDR_LO: db_out <= addr_ext[7:0];
                        REG_ADDR_HI: db_out <= addr_ext[15:8];
                        REG_DATA:    db_out <= 8'h00;
                        default: begin
                            db_out                <= 8'h00;
                            db_out[CTRL_WRAP_BIT] <= wrap_flag;
                        end
                    endcase
                end
            end

            if (state == ST_RELEASE && astb_s && dstb_s) begin
                pwait <= 1'b0;
                db_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_epp_ram_writer.sv
// tb/tb_epp_ram_writer.sv - directed self-checking bench for epp_ram_writer
module tb_epp_ram_writer;

    localparam int ADDR_W = 10;
    localparam int SYNC_N = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              astb_n = 1'b1;
    logic              dstb_n = 1'b1;
    logic              pwr_n = 1'b1;
    logic [7:0]        db_in = 8'h00;
    logic [7:0]        db_out;
    logic              db_oe;
    logic              pwait;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic [15:0]       wr_count;

    int total = 0;
    int bad = 0;
    int we_cnt = 0;
    int pw_rise = 0;
    logic pw_prev = 1'b0;
    logic [17:0] we_log[$];
    logic [7:0]  ram_model [0:(1<<ADDR_W)-1];

    epp_ram_writer #(.ADDR_W(ADDR_W), .SYNC_N(SYNC_N)) dut (
        .clk(clk), .rst(rst), .astb_n(astb_n), .dstb_n(dstb_n), .pwr_n(pwr_n),
        .db_in(db_in), .db_out(db_out), .db_oe(db_oe), .pwait(pwait),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            we_cnt++;
            we_log.push_back({ram_addr, ram_din});
            ram_model[ram_addr] = ram_din;
        end
        if (pwait === 1'b1 && pw_prev !== 1'b1) pw_rise++;
        pw_prev = pwait;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_cycle(input bit addr_cyc, input bit wr, input logic [7:0] d,
                              output logic [7:0] rd);
        int n;
        @(negedge clk);
        pwr_n = ~wr;
        db_in = d;
        if (addr_cyc) astb_n = 1'b0; else dstb_n = 1'b0;
        n = 0;
        while (pwait !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("ack_seen", {31'd0, pwait}, 32'd1);
        rd = db_out;
        if (!wr) chk("read_oe", {31'd0, db_oe}, 32'd1);
        astb_n = 1'b1;
        dstb_n = 1'b1;
        n = 0;
        while (pwait !== 1'b0 && n < 40) begin @(negedge clk); n++; end
        chk("ack_clear", {31'd0, pwait}, 32'd0);
        if (!wr) chk("oe_clear", {31'd0, db_oe}, 32'd0);
        repeat (2) @(negedge clk);
        pwr_n = 1'b1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        host_cycle(1'b1, 1'b1, {6'd0, a}, dummy);
        host_cycle(1'b0, 1'b1, d, dummy);
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [7:0] v);
        logic [7:0] dummy;
        host_cycle(1'b1, 1'b1, {6'd0, a}, dummy);
        host_cycle(1'b0, 1'b0, 8'h00, v);
    endtask

    initial begin
        logic [7:0]  v;
        logic [17:0] e;
        int n, rises, base_we;
        logic [ADDR_W-1:0] expa;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pwait", {31'd0, pwait}, 32'd0);
        chk("rst_oe", {31'd0, db_oe}, 32'd0);
        chk("rst_out", {24'd0, db_out}, 32'd0);
        chk("rst_we", {31'd0, ram_we}, 32'd0);
        chk("rst_addr", {22'd0, ram_addr}, 32'd0);
        chk("rst_din", {24'd0, ram_din}, 32'd0);
        chk("rst_cnt", {16'd0, wr_count}, 32'd0);
        repeat (50) @(negedge clk);
        chk("idle_no_ack", pw_rise, 0);

        wr_reg(2'd0, 8'h34);
        wr_reg(2'd1, 8'h01);
        chk("addr_134", {22'd0, ram_addr}, 32'h134);
        chk("no_we_yet", we_cnt, 0);
        rd_reg(2'd1, v);
        chk("rd_addr_hi", {24'd0, v}, 32'h01);

        wr_reg(2'd2, 8'hAA);
        host_cycle(1'b0, 1'b1, 8'hBB, v);
        host_cycle(1'b0, 1'b1, 8'hCC, v);
        chk("we_cnt3", we_cnt, 3);
        for (int i = 0; i < 3; i++) begin
            expa = ADDR_W'(10'h134 + i);
            e = (we_log.size() > 0) ? we_log.pop_front() : 18'h3FFFF;
            chk("we_addr", {14'd0, e[17:8]}, {22'd0, expa});
            chk("we_data", {24'd0, e[7:0]}, {24'd0, 8'hAA + 8'(i * 17)});
        end
        chk("cnt3", {16'd0, wr_count}, 32'd3);
        chk("addr_137", {22'd0, ram_addr}, 32'h137);
        rd_reg(2'd2, v);
        chk("rd_data_reg", {24'd0, v}, 32'h00);

        wr_reg(2'd0, 8'hFF);
        wr_reg(2'd1, 8'h03);
        wr_reg(2'd2, 8'h55);
        chk("ram_3ff", {24'd0, ram_model[10'h3FF]}, 32'h55);
        chk("addr_wrap", {22'd0, ram_addr}, 32'h0);
        chk("cnt4", {16'd0, wr_count}, 32'd4);
        rd_reg(2'd3, v);
        chk("ctrl_wrap", {24'd0, v}, 32'h01);
        host_cycle(1'b0, 1'b1, 8'h01, v);
        chk("clr_addr", {22'd0, ram_addr}, 32'h0);
        chk("clr_cnt", {16'd0, wr_count}, 32'd0);
        host_cycle(1'b0, 1'b0, 8'h00, v);
        chk("ctrl_clr", {24'd0, v}, 32'h00);

        wr_reg(2'd0, 8'h5A);
        host_cycle(1'b1, 1'b1, 8'h00, v);
        rises = pw_rise;
        @(negedge clk);
        pwr_n = 1'b1;
        dstb_n = 1'b0;
        n = 0;
        while (pwait !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("lat_rise", n, SYNC_N + 2);
        chk("lat_oe", {31'd0, db_oe}, 32'd1);
        chk("lat_out", {24'd0, db_out}, 32'h5A);
        repeat (20 - n) @(negedge clk);
        dstb_n = 1'b1;
        n = 0;
        while (pwait !== 1'b0 && n < 40) begin @(negedge clk); n++; end
        chk("lat_fall", n, SYNC_N + 1);
        chk("single_ack", pw_rise - rises, 1);
        repeat (3) @(negedge clk);

        wr_reg(2'd1, 8'h02);
        host_cycle(1'b1, 1'b1, 8'h02, v);
        base_we = we_cnt;
        @(negedge clk);
        pwr_n = 1'b0;
        db_in = 8'h99;
        dstb_n = 1'b0;
        n = 0;
        while (pwait !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("rst_ack_seen", {31'd0, pwait}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_pwait", {31'd0, pwait}, 32'd0);
        chk("rst_mid_cnt", {16'd0, wr_count}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_hold_noack", {31'd0, pwait}, 32'd0);
        dstb_n = 1'b1;
        pwr_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_one_we", we_cnt - base_we, 1);
        we_log.delete();

        wr_reg(2'd2, 8'h77);
        chk("post_we_cnt", we_cnt - base_we, 2);
        e = (we_log.size() > 0) ? we_log.pop_front() : 18'h3FFFF;
        chk("post_we", {14'd0, e}, {14'd0, 10'h000, 8'h77});
        chk("post_cnt", {16'd0, wr_count}, 32'd1);
        chk("post_addr", {22'd0, ram_addr}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
